// File: rtl/axi_line_mem_responder.sv
// rtl/axi_line_mem_responder.sv - AXI-style line memory responder with aged in-order read queue and backdoor preload
module axi_line_mem_responder #(
  parameter int LOG_LINES    = 10,
  parameter int READ_LAT     = 4,
  parameter int AR_LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          arid,
  input  logic [63:0]          araddr,
  input  logic [7:0]           arlen,
  input  logic [2:0]           arsize,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [15:0]          rid,
  output logic [511:0]         rdata,
  output logic [1:0]           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready,
  input  logic [15:0]          awid,
  input  logic [63:0]          awaddr,
  input  logic [7:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [15:0]          wid,
  input  logic [511:0]         wdata,
  input  logic [63:0]          wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [15:0]          bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic                 bd_wr,
  input  logic [LOG_LINES-1:0] bd_line,
  input  logic [511:0]         bd_data,
  output logic [31:0]          rd_beats,
  output logic [31:0]          wr_beats
);

  localparam int LINES = 1 << LOG_LINES;
  localparam int DEPTH = 1 << AR_LOG_DEPTH;
  // Full line number (address bits 63:6); bits above LOG_LINES flag out-of-range beats
  localparam int LA_W = 58;
  localparam logic [AR_LOG_DEPTH:0] Q_FULL = (AR_LOG_DEPTH + 1)'(DEPTH);

  logic [511:0] mem [LINES];

  // Size fields and low address bits carry no meaning for line-granular access
  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, wid, araddr[5:0], awaddr[5:0]};

  // ---------------------------------------------------------------------------
  // Cycle counter used to timestamp accepted reads
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_cnt;

  // Free-running timestamp source; ages are differences, so wrap is harmless
  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Outstanding-read queue
  // ---------------------------------------------------------------------------
  logic [15:0]             q_id   [DEPTH];
  logic [LA_W-1:0]         q_line [DEPTH];
  logic [7:0]              q_len  [DEPTH];
  logic [31:0]             q_ts   [DEPTH];
  logic [AR_LOG_DEPTH-1:0] q_wr_ptr;
  logic [AR_LOG_DEPTH-1:0] q_rd_ptr;
  logic [AR_LOG_DEPTH:0]   q_count;
  logic                    q_push;
  logic                    q_pop;

  assign arready = !rst && (q_count != Q_FULL);
  assign q_push  = arvalid && arready;
  // The head leaves the queue only once its final beat is accepted
  assign q_pop   = rvalid && rready && rlast;

  // Read request FIFO; entries keep their accept time for latency ageing
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      q_count  <= '0;
    end else begin
      if (q_push) begin
        q_id[q_wr_ptr]   <= arid;
        q_line[q_wr_ptr] <= araddr[63:6];
        q_len[q_wr_ptr]  <= arlen;
        q_ts[q_wr_ptr]   <= cycle_cnt;
        q_wr_ptr         <= q_wr_ptr + AR_LOG_DEPTH'(1);
      end
      if (q_pop) begin
        q_rd_ptr <= q_rd_ptr + AR_LOG_DEPTH'(1);
      end
      case ({q_push, q_pop})
        2'b10:   q_count <= q_count + (AR_LOG_DEPTH + 1)'(1);
        2'b01:   q_count <= q_count - (AR_LOG_DEPTH + 1)'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  logic [15:0]     head_id;
  logic [LA_W-1:0] head_line;
  logic [7:0]      head_len;
  logic [31:0]     head_age;
  logic            head_ready;

  assign head_id   = q_id[q_rd_ptr];
  assign head_line = q_line[q_rd_ptr];
  assign head_len  = q_len[q_rd_ptr];
  assign head_age  = cycle_cnt - q_ts[q_rd_ptr];
  // Launch one cycle early so the registered beat appears exactly READ_LAT after accept
  assign head_ready = (q_count != '0) && (head_age >= 32'(READ_LAT - 1));

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {R_IDLE, R_BEAT} r_state_t;

  r_state_t        r_state;
  logic [7:0]      rk;
  logic [7:0]      rd_k;
  logic [LA_W-1:0] rd_line;
  logic            rd_oor;
  logic [LOG_LINES-1:0] rd_idx;

  // Address of the beat to be loaded at the next edge (first beat or successor)
  always_comb begin
    rd_k    = (r_state == R_IDLE) ? 8'd0 : rk + 8'd1;
    rd_line = head_line + LA_W'(rd_k);
    rd_oor  = |rd_line[LA_W-1:LOG_LINES];
    rd_idx  = rd_line[LOG_LINES-1:0];
  end

  // Issue aged queue heads as bursts of registered RAM reads, holding on stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      rk       <= '0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= '0;
      rid      <= '0;
      rdata    <= '0;
      rd_beats <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (head_ready) begin
            r_state <= R_BEAT;
            rk      <= rd_k;
            rvalid  <= 1'b1;
            rid     <= head_id;
            rlast   <= (head_len == rd_k);
            rresp   <= rd_oor ? 2'b11 : 2'b00;
            rdata   <= rd_oor ? '0 : mem[rd_idx];
          end
        end
        R_BEAT: begin
          if (rready) begin
            rd_beats <= rd_beats + 32'd1;
            if (rlast) begin
              r_state <= R_IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
            end else begin
              rk    <= rd_k;
              rlast <= (head_len == rd_k);
              rresp <= rd_oor ? 2'b11 : 2'b00;
              rdata <= rd_oor ? '0 : mem[rd_idx];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t        w_state;
  logic [15:0]     w_id;
  logic [LA_W-1:0] w_line;
  logic [7:0]      w_len;
  logic [7:0]      wk;
  logic [1:0]      w_err;
  logic            w_fire;
  logic [LA_W-1:0] w_beat_line;
  logic            w_oor;
  logic            w_is_last;
  logic [1:0]      w_err_next;

  assign awready = !rst && (w_state == W_IDLE);
  // Backdoor preload owns the RAM write port in the cycle it is asserted
  assign wready  = !rst && (w_state == W_DATA) && !bd_wr;
  assign w_fire  = wvalid && wready;

  // Per-beat range and framing checks; OR-merge makes DECERR dominate SLVERR
  always_comb begin
    w_beat_line = w_line + LA_W'(wk);
    w_oor       = |w_beat_line[LA_W-1:LOG_LINES];
    w_is_last   = (wk == w_len);
    w_err_next  = w_err | (w_oor ? 2'b11 : 2'b00) | ((wlast != w_is_last) ? 2'b10 : 2'b00);
  end

  // Accept one burst at a time; the burst length alone decides where it ends
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_id     <= '0;
      w_line   <= '0;
      w_len    <= '0;
      wk       <= '0;
      w_err    <= '0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      wr_beats <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_state <= W_DATA;
            w_id    <= awid;
            w_line  <= awaddr[63:6];
            w_len   <= awlen;
            wk      <= '0;
            w_err   <= '0;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wr_beats <= wr_beats + 32'd1;
            w_err    <= w_err_next;
            if (w_is_last) begin
              w_state <= W_RESP;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= w_err_next;
            end else begin
              wk <= wk + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Line RAM
  // ---------------------------------------------------------------------------

  // Backdoor full-line preload wins over byte-strobed AXI writes
  always_ff @(posedge clk) begin
    if (bd_wr) begin
      mem[bd_line] <= bd_data;
    end else if (w_fire && !w_oor) begin
      for (int j = 0; j < 64; j++) begin
        if (wstrb[j]) mem[w_beat_line[LOG_LINES-1:0]][j*8 +: 8] <= wdata[j*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_line_mem_responder.sv
// tb/tb_axi_line_mem_responder.sv - scoreboard and vector-table bench for axi_line_mem_responder
module tb_axi_line_mem_responder;

  localparam int LOG_LINES    = 10;
  localparam int READ_LAT     = 4;
  localparam int AR_LOG_DEPTH = 2;
  localparam int LINES        = 1 << LOG_LINES;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0]  arid = '0;
  logic [63:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic [2:0]   arsize = 3'd6;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [15:0]  rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [15:0]  awid = '0;
  logic [63:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic [2:0]   awsize = 3'd6;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [15:0]  wid = '0;
  logic [511:0] wdata = '0;
  logic [63:0]  wstrb = '0;
  logic         wlast = 1'b0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [15:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic         bd_wr = 1'b0;
  logic [LOG_LINES-1:0] bd_line = '0;
  logic [511:0] bd_data = '0;
  logic [31:0]  rd_beats;
  logic [31:0]  wr_beats;

  always #5 clk = ~clk;

  axi_line_mem_responder #(
    .LOG_LINES(LOG_LINES), .READ_LAT(READ_LAT), .AR_LOG_DEPTH(AR_LOG_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bd_wr(bd_wr), .bd_line(bd_line), .bd_data(bd_data),
    .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  typedef struct {
    logic [15:0]  id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } rbeat_t;

  typedef struct {
    logic [15:0] id;
    logic [1:0]  resp;
  } bexp_t;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [15:0] id;
    logic [7:0]  len;
    logic [63:0] strb;
    int          wlast_at;
    logic [1:0]  exp_bresp;
    logic [63:0] w0;
  } vec_t;

  rbeat_t exp_r[$];
  bexp_t  exp_b[$];
  logic [511:0] ref_mem [LINES];

  int n_checks = 0;
  int n_fail = 0;
  int exp_rd_beats = 0;
  int exp_wr_beats = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic bd_write(input int line, input logic [511:0] d);
    bd_wr = 1'b1;
    bd_line = LOG_LINES'(line);
    bd_data = d;
    cyc();
    bd_wr = 1'b0;
    ref_mem[line] = d;
  endtask

  task automatic push_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    rbeat_t e;
    logic [57:0] la;
    for (int k = 0; k <= int'(len); k++) begin
      la = addr[63:6] + 58'(k);
      e.id = id;
      e.last = (k == int'(len));
      if (la < 58'(LINES)) begin
        e.data = ref_mem[la[LOG_LINES-1:0]];
        e.resp = 2'b00;
      end else begin
        e.data = '0;
        e.resp = 2'b11;
      end
      exp_r.push_back(e);
    end
    exp_rd_beats += int'(len) + 1;
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    int i;
    arid = id;
    araddr = addr;
    arlen = len;
    arvalid = 1'b1;
    for (i = 0; i < 100 && !arready; i++) cyc();
    chk("ar_accept_timeout", arready, 1);
    cyc();
    arvalid = 1'b0;
  endtask

  task automatic wait_r_drain(input int budget, input bit toggle);
    int i;
    for (i = 0; i < budget && exp_r.size() != 0; i++) begin
      cyc();
      if (toggle) rready = ~rready;
    end
    rready = 1'b1;
    chk("r_drain_timeout", exp_r.size(), 0);
  endtask

  task automatic do_write(input vec_t v);
    logic [511:0] d;
    logic [57:0] la;
    bexp_t b;
    int i;
    awid = v.id;
    awaddr = v.addr;
    awlen = v.len;
    awvalid = 1'b1;
    b.id = v.id;
    b.resp = v.exp_bresp;
    exp_b.push_back(b);
    for (i = 0; i < 100 && !awready; i++) cyc();
    chk("aw_accept_timeout", awready, 1);
    cyc();
    awvalid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      d = rand512();
      d[63:0] = v.w0;
      wdata = d;
      wstrb = v.strb;
      wlast = (k == v.wlast_at);
      wid = v.id;
      wvalid = 1'b1;
      for (i = 0; i < 100 && !wready; i++) cyc();
      chk("w_accept_timeout", wready, 1);
      cyc();
      la = v.addr[63:6] + 58'(k);
      if (la < 58'(LINES)) begin
        for (int j = 0; j < 64; j++) begin
          if (v.strb[j]) ref_mem[la[LOG_LINES-1:0]][j*8 +: 8] = d[j*8 +: 8];
        end
      end
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    exp_wr_beats += int'(v.len) + 1;
    for (i = 0; i < 100 && exp_b.size() != 0; i++) cyc();
    chk("b_timeout", exp_b.size(), 0);
  endtask

  // Output monitor on the falling edge: scoreboard pops plus stall-stability checks
  rbeat_t       mon_r;
  bexp_t        mon_b;
  logic         prev_stall = 1'b0;
  logic [15:0]  prev_rid;
  logic [511:0] prev_rdata;
  logic [1:0]   prev_rresp;
  logic         prev_rlast;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("r_hold_rdata", rdata, prev_rdata);
          chk("r_hold_rid", rid, prev_rid);
          chk("r_hold_rresp", rresp, prev_rresp);
          chk("r_hold_rlast", rlast, prev_rlast);
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL r_unexpected: actual rid=%0h required no beat", rid);
          end else begin
            mon_r = exp_r.pop_front();
            chk("r_id", rid, mon_r.id);
            chk("r_data", rdata, mon_r.data);
            chk("r_resp", rresp, mon_r.resp);
            chk("r_last", rlast, mon_r.last);
          end
        end
        prev_stall = rvalid && !rready;
        prev_rid = rid;
        prev_rdata = rdata;
        prev_rresp = rresp;
        prev_rlast = rlast;
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected: actual bid=%0h required no response", bid);
          end else begin
            mon_b = exp_b.pop_front();
            chk("b_id", bid, mon_b.id);
            chk("b_resp", bresp, mon_b.resp);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  vec_t vt[13];
  logic stale;

  initial begin
    vt[0]  = '{1'b1, 64'h80,     16'd7,  8'd0, 64'hFF,                 0, 2'b00, 64'h1234};
    vt[1]  = '{1'b0, 64'h80,     16'd8,  8'd0, 64'h0,                  0, 2'b00, 64'h0};
    vt[2]  = '{1'b1, 64'h100000, 16'd9,  8'd0, 64'hFFFFFFFFFFFFFFFF,   0, 2'b11, 64'hDEAD};
    vt[3]  = '{1'b0, 64'h100000, 16'd10, 8'd0, 64'h0,                  0, 2'b11, 64'h0};
    vt[4]  = '{1'b0, 64'h0,      16'd11, 8'd0, 64'h0,                  0, 2'b00, 64'h0};
    vt[5]  = '{1'b1, 64'h200,    16'd12, 8'd1, 64'hFFFFFFFFFFFFFFFF,   0, 2'b10, 64'hBEEF};
    vt[6]  = '{1'b0, 64'h200,    16'd13, 8'd1, 64'h0,                  0, 2'b00, 64'h0};
    vt[7]  = '{1'b1, 64'hFFC0,   16'd14, 8'd1, 64'hFFFFFFFFFFFFFFFF,   1, 2'b11, 64'hCAFE};
    vt[8]  = '{1'b0, 64'hFFC0,   16'd15, 8'd1, 64'h0,                  0, 2'b00, 64'h0};
    vt[9]  = '{1'b1, 64'h300,    16'd16, 8'd2, 64'h5555555555555555,   2, 2'b00, 64'h1111};
    vt[10] = '{1'b0, 64'h2C0,    16'd17, 8'd4, 64'h0,                  0, 2'b00, 64'h0};
    vt[11] = '{1'b1, 64'h400,    16'd18, 8'd0, 64'hFFFFFFFFFFFFFFFF,   5, 2'b10, 64'h2222};
    vt[12] = '{1'b0, 64'h400,    16'd19, 8'd0, 64'h0,                  0, 2'b00, 64'h0};

    // Reset state
    repeat (3) cyc();
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rd_beats", rd_beats, 0);
    chk("rst_wr_beats", wr_beats, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_arready", arready, 1);
    chk("post_rst_awready", awready, 1);

    // Preload lines touched by the tests
    for (int l = 0; l < 32; l++) bd_write(l, rand512());
    bd_write(LINES - 1, rand512());

    // Single read: exact latency from AR handshake
    push_read(16'd2, 64'h140, 8'd0);
    arid = 16'd2;
    araddr = 64'h140;
    arlen = 8'd0;
    arvalid = 1'b1;
    chk("sr_arready", arready, 1);
    cyc();
    arvalid = 1'b0;
    for (int i = 1; i < READ_LAT; i++) begin
      chk("sr_early_rvalid", rvalid, 0);
      cyc();
    end
    chk("sr_rvalid_at_lat", rvalid, 1);
    cyc();
    chk("sr_rd_beats", rd_beats, 1);
    chk("sr_drained", exp_r.size(), 0);

    // Burst with alternating backpressure
    push_read(16'd3, 64'h0, 8'd3);
    send_ar(16'd3, 64'h0, 8'd3);
    wait_r_drain(200, 1'b1);

    // Queue full and in-order return
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_read(16'(i), 64'((10 + i) * 64), 8'd0);
      arid = 16'(i);
      araddr = 64'((10 + i) * 64);
      arlen = 8'd0;
      arvalid = 1'b1;
      chk("q_accept", arready, 1);
      cyc();
    end
    push_read(16'd4, 64'(14 * 64), 8'd0);
    arid = 16'd4;
    araddr = 64'(14 * 64);
    chk("q_full_arready", arready, 0);
    rready = 1'b1;
    send_ar(16'd4, 64'(14 * 64), 8'd0);
    wait_r_drain(300, 1'b0);

    // Vector table: writes checked on B, reads checked beat by beat
    for (int v = 0; v < 13; v++) begin
      if (vt[v].wr) begin
        do_write(vt[v]);
      end else begin
        push_read(vt[v].id, vt[v].addr, vt[v].len);
        send_ar(vt[v].id, vt[v].addr, vt[v].len);
        wait_r_drain(200, 1'b0);
      end
    end
    chk("cnt_rd_beats", rd_beats, 32'(exp_rd_beats));
    chk("cnt_wr_beats", wr_beats, 32'(exp_wr_beats));

    // Reset in the middle of a read burst
    push_read(16'd20, 64'h500, 8'd3);
    send_ar(16'd20, 64'h500, 8'd3);
    for (int i = 0; i < 50 && !rvalid; i++) cyc();
    chk("rmb_first_beat", rvalid, 1);
    cyc();
    chk("rmb_second_beat", rvalid, 1);
    rst = 1'b1;
    exp_r.delete();
    exp_rd_beats = 0;
    exp_wr_beats = 0;
    cyc();
    chk("rmb_rvalid_after_rst", rvalid, 0);
    chk("rmb_rd_beats_after_rst", rd_beats, 0);
    rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stale = stale | rvalid;
      cyc();
    end
    chk("rmb_no_stale_beats", stale, 0);
    push_read(16'd21, 64'h540, 8'd0);
    send_ar(16'd21, 64'h540, 8'd0);
    wait_r_drain(100, 1'b0);
    chk("rmb_rd_beats_new", rd_beats, 32'(exp_rd_beats));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_line_mem_responder.md
# axi_line_mem_responder

AXI-style memory responder (slave) for the PageRank engine's 512-bit master port. It accepts read and write requests and returns line-granular data from an internal RAM, with a programmable minimum read latency. It stands in for host/DRAM memory in simulation and small-graph FPGA builds. A backdoor port preloads vertex, in-edge and PageRank arrays.

## Interface
- LOG_LINES, 10, RAM depth is 2^LOG_LINES lines of 64 bytes
- READ_LAT, 4, minimum cycles from AR handshake to first R beat (≥1)
- AR_LOG_DEPTH, 2, outstanding-read queue holds 2^AR_LOG_DEPTH requests
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arid/araddr/arlen/arsize/arvalid  in  16/64/8/3/1  read address; arsize ignored
- arready  out  1  read address accept
- rid/rdata/rresp/rlast/rvalid  out  16/512/2/1/1  read data
- rready  in  1  read data accept
- awid/awaddr/awlen/awsize/awvalid  in  16/64/8/3/1  write address; awsize ignored
- awready  out  1  write address accept
- wid/wdata/wstrb/wlast/wvalid  in  16/512/64/1/1  write data; wid ignored
- wready  out  1  write data accept
- bid/bresp/bvalid  out  16/2/1  write response
- bready  in  1  write response accept
- bd_wr/bd_line/bd_data  in  1/LOG_LINES/512  backdoor full-line write
- rd_beats, wr_beats  out  32/32  completed R / W beat counters

## Operation
- Line index = addr[6+LOG_LINES-1:6]; addr[5:0] ignored. Beat k of a burst uses line index + k (INCR only). Beat address with any bit ≥ 6+LOG_LINES set is out of range.
- Read queue: AR handshake pushes {arid, line, arlen, accept_cycle}. Timestamps come from a 32-bit free-running cycle counter; age is computed modulo 2^32. arready = !queue_full.
- Read FSM:
  - R_IDLE → R_BEAT when queue nonempty and head age ≥ READ_LAT.
  - R_BEAT drives rvalid=1, rid=head id, rdata=RAM[line+k], rresp=00 (out of range: 11, rdata=0), rlast=(k==arlen).
  - On rvalid&rready: k++, rd_beats++. On the last beat, pop and go to R_IDLE; a back-to-back head that is already aged may issue the next cycle.
  - R outputs are held stable while rvalid&!rready.
  - Responses are returned in acceptance order.
- Write FSM:
  - W_IDLE (awready=1, wready=0): AW handshake latches id/line/awlen, sets err=0, and goes to W_DATA.
  - W_DATA (awready=0, wready=!bd_wr): each W handshake writes byte j of the line iff wstrb[j] and increments wr_beats.
    - Out-of-range beat: write suppressed, err |= DECERR.
    - wlast mismatch against beat == awlen: err |= SLVERR (DECERR wins).
    - The burst ends after exactly awlen+1 beats regardless of wlast → W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=00/10/11. On bready → W_IDLE.
- Backdoor: bd_wr writes the full line the same cycle. It has priority over AXI writes (wready forced 0 that cycle).
- Collisions: a read beat and a write to the same line in the same cycle return old data. A write whose B handshake precedes an AR handshake is visible to that read.
- RAM contents are not reset.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, bvalid=0, bid=0, bresp=0, rd_beats=0, wr_beats=0. The queue empties and the FSMs go to IDLE.
- First cycle after reset: arready=1, awready=1.
- Read latency: an AR accepted at cycle t gives first rvalid at cycle t+READ_LAT, if the queue ahead is drained and the RAM read is registered internally.
- Burst throughput: 1 beat/cycle with rready held high.
- Write: AW at t → wready at t+1. Last beat at u → bvalid at u+1. Next awready comes the cycle after the B handshake.
- Reset mid-burst: in-flight reads/writes are dropped and no R/B is issued for them. Partially written lines keep the written beats.
- Counters wrap at 2^32.

## Test plan
- **Single read:** backdoor line 5 = pattern P; AR addr 0x140, id 2, len 0 at t → rvalid at t+4, rid=2, rdata=P, rresp=00, rlast=1, rd_beats=1.
- **Burst + backpressure:** AR addr 0, len 3; rready toggles 1,0,1,0… → 4 beats of lines 0..3 in order, data held stable during stalls, rlast only on beat 3.
- **Queue full / ordering:** 5 ARs back-to-back with AR_LOG_DEPTH=2 → arready low after 4 accepts; responses come in id order 0..4.
- **Strobed write then read:** AW 0x80 len 0; W wstrb=0x00000000000000FF, data word0=0x1234 → bresp=00. Read line 2: bytes 0-7 = 0x1234, other bytes unchanged.
- **Errors:** AW addr 1<<20 (LOG_LINES=10) → bresp=11, RAM unchanged. AW len 1 with wlast on beat 0 → bresp=10 after 2 beats. AR addr 1<<20 → rresp=11, rdata=0.
- **Reset mid-burst:** assert rst during beat 1 of a len 3 read → rvalid=0 next cycle; no stale beats after reset; new single read completes normally.
